// File: rtl/input_map_pkg.sv
// input_map_pkg: key map, bit layouts and SOCD helper for arcade_input_mapper
package input_map_pkg;
  localparam int NKEYS = 19;
  localparam int K_P1U = 0, K_P1D = 1, K_P1L = 2, K_P1R = 3;
  localparam int K_P1F = 4, K_P1FA = 5, K_P1FB = 6;
  localparam int K_S1A = 7, K_S1B = 8, K_S2A = 9, K_S2B = 10;
  localparam int K_C1 = 11, K_C2 = 12;
  localparam int K_P2U = 13, K_P2D = 14, K_P2L = 15, K_P2R = 16, K_P2F = 17;
  localparam int K_TEST = 18;
  // {ext, code}; 014 appears with both ext values so each is tracked on its own
  localparam logic [8:0] KEY_MAP [NKEYS] = '{
    9'h175, 9'h172, 9'h16B, 9'h174, 9'h029, 9'h014, 9'h114,
    9'h005, 9'h016, 9'h006, 9'h01E, 9'h02E, 9'h036,
    9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h02C};
  localparam int CTL_R = 0, CTL_L = 1, CTL_D = 2, CTL_U = 3, CTL_F = 4;
  localparam int JOY_R = 0, JOY_L = 1, JOY_D = 2, JOY_U = 3, JOY_F = 4;
  localparam int JOY_S1 = 5, JOY_S2 = 6, JOY_COIN = 7;
  function automatic logic [1:0] socd_clean(input logic [1:0] d);
    return (&d) ? 2'b00 : d;
  endfunction
endpackage

// File: rtl/coin_pulser.sv
// coin_pulser: turns rising edges of a coin source into fixed-width pulses
module coin_pulser #(
  parameter int COIN_PULSE = 12000
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic i_src,
  output logic o_pulse
);
  if (COIN_PULSE == 0) begin : g_pass
    logic r_pulse;
    always_ff @(posedge clk_sys) r_pulse <= reset ? 1'b0 : i_src;
    assign o_pulse = r_pulse;
  end else begin : g_cnt
    localparam int CW = $clog2(COIN_PULSE + 1);
    logic r_prev;
    logic [CW-1:0] r_cnt;
    // edges arriving while a pulse is running are dropped, but r_prev still tracks
    always_ff @(posedge clk_sys) begin
      if (reset) begin
        r_prev <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_prev <= i_src;
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
        else if (i_src && !r_prev) r_cnt <= CW'(COIN_PULSE);
      end
    end
    assign o_pulse = r_cnt != '0;
  end
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: ps2 keyboard + HPS joystick front end producing
// per-player controls, start, coin pulses and test for arcade cores
module arcade_input_mapper
  import input_map_pkg::*;
#(
  parameter int PLAYERS     = 2,
  parameter int MERGE_JOY   = 0,
  parameter int START_COINS = 1,
  parameter int COIN_PULSE  = 12000,
  parameter int SOCD        = 0
) (
  input  logic                 clk_sys,
  input  logic                 reset,
  input  logic [10:0]          ps2_key,
  input  logic [15:0]          joystick_0,
  input  logic [15:0]          joystick_1,
  input  logic                 rotate,
  output logic [PLAYERS*5-1:0] p_ctrl,
  output logic [PLAYERS-1:0]   start,
  output logic [PLAYERS-1:0]   coin,
  output logic                 test
);
  logic             r_old_tog;
  logic [NKEYS-1:0] r_keys;
  logic [PLAYERS*5-1:0] r_ctrl, w_ctrl;
  logic [PLAYERS-1:0]   r_start, w_start, w_src;
  logic             r_test;
  logic             w_event;
  logic [15:0]      w_jall, w_jst;
  logic [3:0]       w_kdir [2];
  logic             w_kfire [2];
  logic             w_kstart [2];
  logic             w_kcoin [2];
  assign w_event = ps2_key[10] ^ r_old_tog;
  // old_tog follows the toggle even in reset, so leaving reset never fakes an event
  always_ff @(posedge clk_sys) begin
    r_old_tog <= ps2_key[10];
    if (reset) r_keys <= '0;
    else if (w_event)
      for (int k = 0; k < NKEYS; k++)
        if (ps2_key[8:0] == KEY_MAP[k]) r_keys[k] <= ps2_key[9];
  end
  assign w_kdir[0]   = {r_keys[K_P1U], r_keys[K_P1D], r_keys[K_P1L], r_keys[K_P1R]};
  assign w_kdir[1]   = {r_keys[K_P2U], r_keys[K_P2D], r_keys[K_P2L], r_keys[K_P2R]};
  assign w_kfire[0]  = r_keys[K_P1F] | r_keys[K_P1FA] | r_keys[K_P1FB];
  assign w_kfire[1]  = r_keys[K_P2F];
  assign w_kstart[0] = r_keys[K_S1A] | r_keys[K_S1B];
  assign w_kstart[1] = r_keys[K_S2A] | r_keys[K_S2B];
  assign w_kcoin[0]  = r_keys[K_C1];
  assign w_kcoin[1]  = r_keys[K_C2];
  assign w_jall = joystick_0 | joystick_1;
  assign w_jst  = (MERGE_JOY != 0) ? w_jall : joystick_0;
  for (genvar p = 0; p < PLAYERS; p++) begin : g_pl
    logic [15:0] w_joy;
    logic [3:0]  w_dir, w_rot;
    assign w_joy = (MERGE_JOY != 0) ? w_jall : (p == 0 ? joystick_0 : joystick_1);
    assign w_dir = w_kdir[p] | w_joy[JOY_U:JOY_R];
    // rotated {U,D,L,R} = {L,R,D,U}
    assign w_rot = rotate ? {w_dir[CTL_L], w_dir[CTL_R], w_dir[CTL_D], w_dir[CTL_U]} : w_dir;
    assign w_ctrl[5*p +: 5] = {w_kfire[p] | w_joy[JOY_F],
      (SOCD != 0) ? {socd_clean(w_rot[3:2]), socd_clean(w_rot[1:0])} : w_rot};
    assign w_start[p] = w_kstart[p] | w_jst[JOY_S1 + p];
    assign w_src[p]   = w_kcoin[p] | w_joy[JOY_COIN] | ((START_COINS != 0) && w_start[p]);
    coin_pulser #(.COIN_PULSE(COIN_PULSE)) u_coin (
      .clk_sys(clk_sys),
      .reset  (reset),
      .i_src  (w_src[p]),
      .o_pulse(coin[p])
    );
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_ctrl  <= '0;
      r_start <= '0;
      r_test  <= 1'b0;
    end else begin
      r_ctrl  <= w_ctrl;
      r_start <= w_start;
      r_test  <= r_keys[K_TEST];
    end
  end
  assign p_ctrl = r_ctrl;
  assign start  = r_start;
  assign test   = r_test;
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed vector table plus hand sequences for coin/reset
module tb_arcade_input_mapper;
  logic        clk_sys = 1'b0;
  logic        reset;
  logic [10:0] ps2_key;
  logic [15:0] joystick_0, joystick_1;
  logic        rotate;
  logic [9:0]  p_ctrl;
  logic [1:0]  start, coin;
  logic        test;
  int n_chk = 0, n_fail = 0;
  int hi0 = 0, hi1 = 0, ri0 = 0, ri1 = 0;
  logic pc0 = 1'b0, pc1 = 1'b0;
  logic tog = 1'b0;
  int s_hi, s_ri, s_ri0;

  arcade_input_mapper #(.PLAYERS(2), .MERGE_JOY(0), .START_COINS(1), .COIN_PULSE(10), .SOCD(1)) dut (
    .clk_sys(clk_sys), .reset(reset), .ps2_key(ps2_key), .joystick_0(joystick_0),
    .joystick_1(joystick_1), .rotate(rotate), .p_ctrl(p_ctrl), .start(start),
    .coin(coin), .test(test));

  always #5 clk_sys = ~clk_sys;

  always @(negedge clk_sys) begin
    hi0 <= hi0 + int'(coin[0]);
    hi1 <= hi1 + int'(coin[1]);
    ri0 <= ri0 + int'(coin[0] & ~pc0);
    ri1 <= ri1 + int'(coin[1] & ~pc1);
    pc0 <= coin[0];
    pc1 <= coin[1];
  end

  typedef struct {
    logic        ev;
    logic        pr;
    logic [8:0]  code;
    logic [15:0] j0, j1;
    logic        rot;
    int          lat;
    logic [9:0]  ectrl;
    logic [1:0]  est;
    logic        etest;
  } vec_t;
  vec_t vec [23];

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic key(input logic pr, input logic [8:0] code);
    tog = ~tog;
    ps2_key = {tog, pr, code};
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    vec[0]  = '{1, 1, 9'h175, 16'h0, 16'h0, 0, 2, 10'h008, 2'b00, 0};
    vec[1]  = '{1, 0, 9'h175, 16'h0, 16'h0, 0, 2, 10'h000, 2'b00, 0};
    vec[2]  = '{1, 1, 9'h075, 16'h0, 16'h0, 0, 2, 10'h000, 2'b00, 0};
    vec[3]  = '{1, 1, 9'h172, 16'h0, 16'h0, 0, 2, 10'h004, 2'b00, 0};
    vec[4]  = '{1, 0, 9'h172, 16'h0, 16'h0, 0, 2, 10'h000, 2'b00, 0};
    vec[5]  = '{1, 1, 9'h014, 16'h0, 16'h0, 0, 2, 10'h010, 2'b00, 0};
    vec[6]  = '{1, 1, 9'h114, 16'h0, 16'h0, 0, 2, 10'h010, 2'b00, 0};
    vec[7]  = '{1, 0, 9'h014, 16'h0, 16'h0, 0, 2, 10'h010, 2'b00, 0};
    vec[8]  = '{1, 0, 9'h114, 16'h0, 16'h0, 0, 2, 10'h000, 2'b00, 0};
    vec[9]  = '{1, 1, 9'h02D, 16'h0, 16'h0, 0, 2, 10'h100, 2'b00, 0};
    vec[10] = '{1, 0, 9'h02D, 16'h0, 16'h0, 0, 2, 10'h000, 2'b00, 0};
    vec[11] = '{1, 1, 9'h01C, 16'h0, 16'h0, 0, 2, 10'h200, 2'b00, 0};
    vec[12] = '{1, 0, 9'h01C, 16'h0, 16'h0, 0, 2, 10'h000, 2'b00, 0};
    vec[13] = '{1, 1, 9'h02C, 16'h0, 16'h0, 0, 2, 10'h000, 2'b00, 1};
    vec[14] = '{1, 0, 9'h02C, 16'h0, 16'h0, 0, 2, 10'h000, 2'b00, 0};
    vec[15] = '{0, 0, 9'h000, 16'h0008, 16'h0, 1, 1, 10'h001, 2'b00, 0};
    vec[16] = '{0, 0, 9'h000, 16'h0003, 16'h0, 0, 1, 10'h000, 2'b00, 0};
    vec[17] = '{0, 0, 9'h000, 16'h000C, 16'h0, 0, 1, 10'h000, 2'b00, 0};
    vec[18] = '{0, 0, 9'h000, 16'h0005, 16'h0, 1, 1, 10'h006, 2'b00, 0};
    vec[19] = '{0, 0, 9'h000, 16'h0000, 16'h0010, 0, 1, 10'h200, 2'b00, 0};
    vec[20] = '{0, 0, 9'h000, 16'h0000, 16'h0001, 0, 1, 10'h020, 2'b00, 0};
    vec[21] = '{1, 1, 9'h16B, 16'h0, 16'h0, 0, 2, 10'h002, 2'b00, 0};
    vec[22] = '{1, 0, 9'h16B, 16'h0, 16'h0, 0, 2, 10'h000, 2'b00, 0};

    reset = 1'b1; ps2_key = '0; joystick_0 = '0; joystick_1 = '0; rotate = 1'b0;
    tick(3);
    chk("reset_outputs", {20'h0, p_ctrl, start, coin, test}, 32'h0);
    reset = 1'b0;
    tick(2);

    for (int i = 0; i < 23; i++) begin
      if (vec[i].ev) key(vec[i].pr, vec[i].code);
      joystick_0 = vec[i].j0;
      joystick_1 = vec[i].j1;
      rotate     = vec[i].rot;
      tick(vec[i].lat);
      chk($sformatf("vec%0d_ctrl", i), {22'h0, p_ctrl}, {22'h0, vec[i].ectrl});
      chk($sformatf("vec%0d_start", i), {30'h0, start}, {30'h0, vec[i].est});
      chk($sformatf("vec%0d_test", i), {31'h0, test}, {31'h0, vec[i].etest});
    end
    joystick_0 = '0; joystick_1 = '0; rotate = 1'b0;
    tick(2);

    // start keys: F1 and '1' tracked independently, one coin pulse overall
    s_hi = hi0; s_ri = ri0;
    key(1, 9'h005);
    tick(1);
    chk("start_coin_early", {31'h0, coin[0]}, 32'h0);
    tick(1);
    chk("start_coin_on", {31'h0, coin[0]}, 32'h1);
    chk("start_f1", {30'h0, start}, 32'h1);
    key(1, 9'h016); tick(2);
    key(0, 9'h005); tick(2);
    chk("start_held_by_1", {30'h0, start}, 32'h1);
    key(0, 9'h016); tick(2);
    chk("start_released", {30'h0, start}, 32'h0);
    tick(15);
    chk("start_coin_rises", ri0 - s_ri, 1);
    chk("start_coin_width", hi0 - s_hi, 10);

    // joystick_1 coin: held source, re-rise, in-pulse edge
    s_hi = hi1; s_ri = ri1; s_ri0 = ri0;
    joystick_1 = 16'h0080; tick(1);
    chk("joy_coin_on", {31'h0, coin[1]}, 32'h1);
    tick(29);
    joystick_1 = 16'h0000; tick(3);
    joystick_1 = 16'h0080; tick(15);
    joystick_1 = 16'h0000; tick(5);
    chk("joy_coin_rises", ri1 - s_ri, 2);
    chk("joy_coin_width", hi1 - s_hi, 20);
    chk("joy_coin_p0_idle", ri0 - s_ri0, 0);
    s_hi = hi1; s_ri = ri1;
    joystick_1 = 16'h0080; tick(2);
    joystick_1 = 16'h0000; tick(1);
    joystick_1 = 16'h0080; tick(1);
    joystick_1 = 16'h0000; tick(15);
    chk("inpulse_rises", ri1 - s_ri, 1);
    chk("inpulse_width", hi1 - s_hi, 10);

    // reset mid-pulse, then toggle ps2 during reset
    joystick_1 = 16'h0080; tick(5);
    chk("midpulse_active", {31'h0, coin[1]}, 32'h1);
    reset = 1'b1; joystick_1 = '0;
    tick(1);
    chk("midpulse_cut", {31'h0, coin[1]}, 32'h0);
    key(1, 9'h175);
    tick(3);
    chk("reset_hold_outputs", {20'h0, p_ctrl, start, coin, test}, 32'h0);
    reset = 1'b0;
    tick(3);
    chk("post_reset_no_event", {20'h0, p_ctrl, start, coin, test}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
